// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM state type and digit-adjust constants for the binary-to-BCD converter.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
    localparam int         DIGIT_W        = 4;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational "if >= 5 then add 3" cell applied to one BCD digit before each shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-packed-BCD converter, one shift/adjust per clock.
// Optional leading-zero blank mask enabled by defining BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = 8,
    parameter int DIG_N = 3
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       start,
    input  logic [BIN_W-1:0]           bin,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIG_N-1:0]   bcd,
    output logic [DIG_N-1:0]           blank
);
    localparam int BCD_W = DIGIT_W * DIG_N;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state, state_next;
    logic [BIN_W-1:0]   bin_reg;
    logic [BCD_W-1:0]   scratch, adj;
    logic [CNT_W-1:0]   cnt;

    for (genvar g = 0; g < DIG_N; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[DIGIT_W*g +: DIGIT_W]),
            .dout (adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = (cnt == CNT_W'(1)) ? DONE : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            done    <= 1'b0;
            bcd     <= '0;
            bin_reg <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            done  <= (state == DONE);
            unique case (state)
                IDLE: if (start) begin
                    bin_reg <= bin;
                    scratch <= '0;
                    cnt     <= CNT_W'(BIN_W);
                end
                SHIFT: begin
                    // {scratch, bin_reg} shifted left by one after the digit adjust
                    scratch <= {adj[BCD_W-2:0], bin_reg[BIN_W-1]};
                    bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                end
                DONE:    bcd <= scratch;
                default: ;
            endcase
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIG_N-1:0] blank_next;

    // Walk from the top digit down; a digit blanks only while everything above it is zero too.
    always_comb begin
        logic zero_above;
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = DIG_N - 1; i >= 0; i--) begin
            zero_above    = zero_above & (scratch[DIGIT_W*i +: DIGIT_W] == '0);
            blank_next[i] = (i != 0) && zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (clr)
            blank <= '0;
        else if (state == DONE)
            blank <= blank_next;
    end
`else
    assign blank = '0;
`endif
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative shift-add-3 (double-dabble) converter from binary to packed BCD.
- Sits directly downstream of the square-root core: consumes its result (or the raw 8-bit operand) on a start pulse and produces packed BCD digits for the 7-segment scan/display stage.
- Uses one shift/adjust iteration per clock, so there is no wide combinational adder chain.

Parameters:
- BIN_W, 8, width of the binary input; also the number of iterations.
- DIG_N, 3, number of BCD output digits; must satisfy 10^DIG_N > 2^BIN_W - 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- bin  in  BIN_W  binary value; latched on an accepted start.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse when bcd is updated.
- bcd  out  4*DIG_N  packed BCD; digit 0 is in bits [3:0]; holds its value between conversions.
- blank  out  DIG_N  leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset (clr=1 at a clock edge):
  - state goes to IDLE.
  - busy=0, done=0, bcd=0, blank=0.
  - The internal shift register and iteration counter are cleared.
  - clr wins over a simultaneous start.
  - clr mid-conversion aborts it; the partial result is never published.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - done=0.
  - If start=1: latch bin into the binary shift register, clear the BCD scratch register, load the counter with BIN_W, go to SHIFT.
- SHIFT, once per cycle:
  - For every scratch digit >= 5, add 3, which keeps the digit 4-bit.
  - Then shift the concatenation {scratch, binreg} left by 1.
  - Decrement the counter; when it reaches 1 before the decrement, go to DONE.
  - Exactly BIN_W SHIFT cycles occur.
- DONE:
  - Copy scratch into bcd.
  - Pulse done=1 for this cycle only.
  - Go to IDLE unconditionally.
  - A start asserted during DONE is ignored.
- Latency:
  - With start accepted at edge N, bcd is valid and done=1 in the cycle after edge N+BIN_W+1.
  - For BIN_W=8, done is visible 9 cycles after the start edge.
  - The next start can be accepted at the edge following the done cycle.
- start while busy=1 is ignored. No queueing; bin is not re-sampled.
- bin changing during a conversion has no effect, because it is latched.
- Width rules:
  - Upper unused digit bits are always 0. For BIN_W=8, DIG_N=3, bcd[11:10]=0.
  - A 10-bit consumer takes bcd[9:0].
- busy = (state != IDLE), registered-state derived, no combinational path from start.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - blank[i]=1 iff digit i and all higher digits are 0, for i >= 1.
  - blank[0] is always 0, so a value of 0 shows a single "0".
  - blank is updated in the same DONE cycle as bcd and is reset to 0.
  - Example: bcd=0x036 gives blank=3'b100.
- Undefined: blank is tied to all zeros; the display stage shows every digit.

Decomposition:
- Shared package bcd_pkg:
  - state typedef {IDLE, SHIFT, DONE}.
  - BCD_ADJ_THRESH=4'd5.
  - BCD_ADJ_ADD=4'd3.
  - DIGIT_W=4.
- One natural sub-module: bcd_digit_adj, a combinational 4-bit "if >= 5 then +3" cell, instantiated DIG_N times via generate.

Test Plan:
- clr pulse, then start with bin=0 → busy for 9 cycles, done pulse, bcd=12'h000; blank=3'b110 with the macro, 3'b000 without.
- bin=36 plus a start pulse → done 9 cycles later, bcd=12'h036, bcd[11:10]=0; blank=3'b100 with the macro.
- bin=150 → bcd=12'h150. Then bin=255 → bcd=12'h255. bcd holds 0x150 until the 255 conversion's done cycle.
- start with bin=36, then start with bin=99 on cycle 3 and again in the DONE cycle → both ignored; result 0x036; exactly one done pulse.
- start with bin=255, clr asserted on cycle 4 → busy=0, bcd=0 on the next cycle, no done pulse; a later start with bin=7 gives 0x007.
- Exhaustive sweep bin=0..255, back-to-back starts issued the cycle after each done → every bcd matches the decimal reference model; latency is constant at 9 cycles.
